// File: rtl/gobou_layer_sched_pkg.sv
// Shared types and widths for the gobou layer scheduler: layer-table entry
// layout and scheduler state encoding.
package gobou_layer_sched_pkg;

    localparam int MEMSIZE       = 12;
    localparam int GOBOU_NETSIZE = 16;
    localparam int LWIDTH        = 10;

    typedef struct packed {
        logic [MEMSIZE-1:0]       in_offset;
        logic [MEMSIZE-1:0]       out_offset;
        logic [GOBOU_NETSIZE-1:0] net_offset;
        logic [LWIDTH-1:0]        total_out;
        logic [LWIDTH-1:0]        total_in;
        logic                     bias_en;
        logic                     relu_en;
    } gobou_layer_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT_LO,
        S_WAIT_HI,
        S_DONE
    } gobou_sched_state_t;

endpackage

// File: rtl/gobou_layer_sched_if.sv
// Scheduler <-> gobou_ctrl_core link: req/ack handshake plus per-run parameters.
interface gobou_layer_sched_if;
    import gobou_layer_sched_pkg::*;

    logic                     core_req;
    logic                     core_ack;
    logic [MEMSIZE-1:0]       in_offset;
    logic [MEMSIZE-1:0]       out_offset;
    logic [GOBOU_NETSIZE-1:0] net_offset;
    logic [LWIDTH-1:0]        total_out;
    logic [LWIDTH-1:0]        total_in;
    logic                     bias_en;
    logic                     relu_en;

    modport master (
        output core_req, in_offset, out_offset, net_offset,
               total_out, total_in, bias_en, relu_en,
        input  core_ack
    );

    modport slave (
        input  core_req, in_offset, out_offset, net_offset,
               total_out, total_in, bias_en, relu_en,
        output core_ack
    );

endinterface

// File: rtl/gobou_layer_table.sv
// Layer-table register file: one write port, one registered read port whose
// output register doubles as the scheduler's parameter register.
module gobou_layer_table
    import gobou_layer_sched_pkg::*;
#(
    parameter int LAYERS   = 8,
    parameter int LAYERLOG = $clog2(LAYERS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [LAYERLOG-1:0] wr_idx,
    input  gobou_layer_t        wr_data,
    input  logic                rd_en,
    input  logic [LAYERLOG-1:0] rd_idx,
    output gobou_layer_t        rd_data
);

    gobou_layer_t mem [LAYERS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAYERS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A write to the entry being read in the same cycle returns the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/gobou_layer_sched.sv
// Multi-layer sequencer for gobou_ctrl_core: walks the layer table, one req/ack per layer.
// Optional GOBOU_SCHED_PERF_EN adds run_cycles / last_layer_cycles counters.
module gobou_layer_sched
    import gobou_layer_sched_pkg::*;
#(
    parameter int LAYERS   = 8,
    parameter int LAYERLOG = $clog2(LAYERS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [LAYERLOG-1:0] cfg_idx,
    input  gobou_layer_t        cfg_entry,
    input  logic                start,
    input  logic [LAYERLOG:0]   num_layers,
    input  logic                abort,
    gobou_layer_sched_if.master core,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LAYERLOG-1:0] cur_layer
`ifdef GOBOU_SCHED_PERF_EN
    ,
    output logic [31:0]         run_cycles,
    output logic [31:0]         last_layer_cycles
`endif
);

    gobou_sched_state_t state, state_nxt;
    gobou_layer_t       params;
    logic [LAYERLOG:0]  nl_q;
    logic [LAYERLOG:0]  nl_clamped;
    logic [LAYERLOG:0]  layer_num;
    logic               abort_pend;
    logic               start_acc;
    logic               last_layer;
    logic               layer_end;

    assign nl_clamped = (num_layers > LAYERS[LAYERLOG:0]) ? LAYERS[LAYERLOG:0] : num_layers;
    assign start_acc  = (state == S_IDLE) && start;
    assign layer_num  = {1'b0, cur_layer} + (LAYERLOG+1)'(1);
    assign last_layer = (layer_num == nl_q);
    assign layer_end  = (state == S_WAIT_HI) && core.core_ack;

    gobou_layer_table #(
        .LAYERS   (LAYERS),
        .LAYERLOG (LAYERLOG)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wr_idx  (cfg_idx),
        .wr_data (cfg_entry),
        .rd_en   (state == S_LOAD),
        .rd_idx  (cur_layer),
        .rd_data (params)
    );

    assign core.in_offset  = params.in_offset;
    assign core.out_offset = params.out_offset;
    assign core.net_offset = params.net_offset;
    assign core.total_out  = params.total_out;
    assign core.total_in   = params.total_in;
    assign core.bias_en    = params.bias_en;
    assign core.relu_en    = params.relu_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        core.core_req = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (nl_clamped == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD:    state_nxt = S_REQ;
            S_REQ: begin
                core.core_req = 1'b1;
                state_nxt     = S_WAIT_LO;
            end
            S_WAIT_LO: if (!core.core_ack) state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (core.core_ack)  state_nxt = (last_layer || abort_pend) ? S_DONE : S_LOAD;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
        aborted = done && abort_pend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_layer  <= '0;
            nl_q       <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (start_acc) begin
                cur_layer <= '0;
                nl_q      <= nl_clamped;
            end else if (layer_end && !last_layer && !abort_pend) begin
                cur_layer <= cur_layer + LAYERLOG'(1);
            end
            if (state == S_DONE)                  abort_pend <= 1'b0;
            else if (abort && (state != S_IDLE)) abort_pend <= 1'b1;
        end
    end

`ifdef GOBOU_SCHED_PERF_EN
    logic [31:0] layer_cnt;

    // layer_cnt counts from the REQ cycle onward, so the exit cycle adds the final +1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cycles        <= '0;
            last_layer_cycles <= '0;
            layer_cnt         <= '0;
        end else begin
            if (start_acc)                   run_cycles <= '0;
            else if (busy && run_cycles != '1) run_cycles <= run_cycles + 32'd1;

            if (start_acc)      last_layer_cycles <= '0;
            else if (layer_end) last_layer_cycles <= layer_cnt + 32'd1;

            if (state == S_REQ)
                layer_cnt <= 32'd1;
            else if ((state == S_WAIT_LO) || (state == S_WAIT_HI))
                layer_cnt <= layer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gobou_layer_sched.sv
// Self-checking bench for gobou_layer_sched: table-driven runs, hand-written corner
// sequences and randomized runs against a shadow table model and a BFM core.
module tb_gobou_layer_sched;
    import gobou_layer_sched_pkg::*;

    localparam int LAYERS   = 8;
    localparam int LAYERLOG = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_we;
    logic [LAYERLOG-1:0] cfg_idx;
    gobou_layer_t        cfg_entry;
    logic                start;
    logic [LAYERLOG:0]   num_layers;
    logic                abort;
    logic                busy, done, aborted;
    logic [LAYERLOG-1:0] cur_layer;
`ifdef GOBOU_SCHED_PERF_EN
    logic [31:0]         run_cycles, last_layer_cycles;
`endif

    gobou_layer_sched_if core ();

    gobou_layer_sched #(.LAYERS(LAYERS), .LAYERLOG(LAYERLOG)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_entry  (cfg_entry),
        .start      (start),
        .num_layers (num_layers),
        .abort      (abort),
        .core       (core.master),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .cur_layer  (cur_layer)
`ifdef GOBOU_SCHED_PERF_EN
        ,
        .run_cycles        (run_cycles),
        .last_layer_cycles (last_layer_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shadow copy of what the host has written into the layer table.
    gobou_layer_t model_tab [LAYERS];

    function automatic gobou_layer_t cur_params();
        gobou_layer_t e;
        e.in_offset  = core.in_offset;
        e.out_offset = core.out_offset;
        e.net_offset = core.net_offset;
        e.total_out  = core.total_out;
        e.total_in   = core.total_in;
        e.bias_en    = core.bias_en;
        e.relu_en    = core.relu_en;
        return e;
    endfunction

    function automatic gobou_layer_t rand_entry();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return gobou_layer_t'(r[$bits(gobou_layer_t)-1:0]);
    endfunction

    // BFM core: on a req, drop ack the next cycle and raise it core_lat cycles later.
    int           core_lat = 20;
    gobou_layer_t obs_q[$];
    int           obs_layer_q[$];

    initial begin
        core.core_ack = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (core.core_req === 1'b1) begin
                obs_q.push_back(cur_params());
                obs_layer_q.push_back(int'(cur_layer));
                @(posedge clk); #1 core.core_ack = 1'b0;
                repeat (core_lat) @(posedge clk);
                #1 core.core_ack = 1'b1;
            end
        end
    end

    int   done_cnt = 0;
    int   busy_cyc = 0;
    logic last_aborted = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            last_aborted = aborted;
        end
        if (busy === 1'b1) busy_cyc++;
    end

    task automatic cfg_write_dut(input int idx, input gobou_layer_t e);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = LAYERLOG'(idx); cfg_entry = e;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input gobou_layer_t e);
        cfg_write_dut(idx, e);
        model_tab[idx] = e;
    endtask

    function automatic int model_reqs(input int nl, input int abort_layer);
        int n;
        n = (nl > LAYERS) ? LAYERS : nl;
        if (abort_layer >= 0 && abort_layer + 1 < n) n = abort_layer + 1;
        return n;
    endfunction

    // Per layer: LOAD + REQ + one WAIT_LO cycle + lat WAIT_HI cycles; plus the DONE cycle.
    function automatic int model_busy(input int reqs, input int lat);
        return reqs * (lat + 3) + 1;
    endfunction

    task automatic run_check(input string tag, input int nl, input int abort_layer, input int lat,
                             input int exp_reqs, input bit exp_ab, input int exp_busy);
        int t;
        core_lat = lat;
        obs_q.delete();
        obs_layer_q.delete();
        done_cnt = 0;
        busy_cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; num_layers = (LAYERLOG+1)'(nl);
        @(posedge clk); #1 start = 1'b0;
        if (abort_layer >= 0) begin
            t = 0;
            while (obs_q.size() < abort_layer + 1 && t < 3000) begin
                @(posedge clk); #2; t++;
            end
            chk({tag, "_abort_wait"}, 64'(t < 3000), 64'd1);
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 5000) begin
            @(negedge clk); t++;
        end
        chk({tag, "_done_timeout"}, 64'(t < 5000), 64'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        chk({tag, "_aborted"}, 64'(last_aborted), 64'(exp_ab));
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
        chk({tag, "_req_cnt"}, 64'(obs_q.size()), 64'(exp_reqs));
        for (int i = 0; i < obs_q.size() && i < exp_reqs; i++) begin
            chk($sformatf("%s_params%0d", tag, i), 64'(obs_q[i]), 64'(model_tab[i]));
            chk($sformatf("%s_layer%0d", tag, i), 64'(obs_layer_q[i]), 64'(i));
        end
`ifdef GOBOU_SCHED_PERF_EN
        chk({tag, "_run_cycles"}, 64'(run_cycles), 64'(exp_busy));
        if (exp_reqs > 0) chk({tag, "_last_layer_cycles"}, 64'(last_layer_cycles), 64'(lat + 2));
`endif
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_core_req"}, 64'(core.core_req), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'({done, aborted}), 64'd0);
        chk({tag, "_cur_layer"}, 64'(cur_layer), 64'd0);
        chk({tag, "_params"}, 64'(cur_params()), 64'd0);
    endtask

    typedef struct {
        int nl;
        int abort_layer;
        int lat;
        int exp_reqs;
        bit exp_ab;
        int exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        gobou_layer_t e;
        int nl, ab, lat, reqs, t;

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_entry = '0;
        start = 1'b0; num_layers = '0; abort = 1'b0;
        for (int i = 0; i < LAYERS; i++) model_tab[i] = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset_idle");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            e = rand_entry();
            e.total_in  = LWIDTH'(16 >> i);
            e.total_out = LWIDTH'(8 >> i);
            cfg_write(i, e);
        end
        for (int i = 3; i < LAYERS; i++) cfg_write(i, rand_entry());

        //          nl  abort lat reqs ab busy
        vecs[0] = '{ 3,  -1,  20,  3,  0,  70};
        vecs[1] = '{ 0,  -1,   5,  0,  0,   1};
        vecs[2] = '{ 4,   1,   6,  2,  1,  19};
        vecs[3] = '{ 8,  -1,   2,  8,  0,  41};
        vecs[4] = '{12,  -1,   1,  8,  0,  33};
        vecs[5] = '{ 1,   0,   3,  1,  1,   7};
        for (int v = 0; v < 6; v++)
            run_check($sformatf("vec%0d", v), vecs[v].nl, vecs[v].abort_layer, vecs[v].lat,
                      vecs[v].exp_reqs, vecs[v].exp_ab, vecs[v].exp_busy);

        // abort while idle must not leak into the next run
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        run_check("idle_abort", 2, -1, 4, 2, 1'b0, 15);

        // second start and a rewrite of entry 2 while layer 1 is running
        fork
            run_check("busy_start", 3, -1, 10, 3, 1'b0, 40);
            begin
                @(posedge clk); #2;
                t = 0;
                while (obs_q.size() < 2 && t < 3000) begin
                    @(posedge clk); #2; t++;
                end
                chk("busy_start_wait", 64'(t < 3000), 64'd1);
                #1 start = 1'b1; num_layers = 4'd1;
                @(posedge clk); #1 start = 1'b0;
                cfg_write(2, rand_entry());
            end
        join

        // write to entry 1 in the very cycle it is loaded: old value is used this run
        e = rand_entry();
        fork
            run_check("load_coll", 2, -1, 6, 2, 1'b0, 19);
            begin
                @(posedge clk); #2;
                t = 0;
                while (obs_q.size() < 1 && t < 3000) begin
                    @(posedge clk); #2; t++;
                end
                chk("load_coll_wait", 64'(t < 3000), 64'd1);
                repeat (8) @(posedge clk);
                #1 cfg_we = 1'b1; cfg_idx = 3'd1; cfg_entry = e;
                @(posedge clk); #1 cfg_we = 1'b0;
            end
        join
        model_tab[1] = e;
        run_check("load_after", 2, -1, 3, 2, 1'b0, 13);

        // mid-run reset: everything back to zero, including the table
        core_lat = 20;
        @(posedge clk); #1 start = 1'b1; num_layers = 4'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet("reset_run");
        rst = 1'b0;
        for (int i = 0; i < LAYERS; i++) model_tab[i] = '0;
        repeat (30) @(negedge clk);
        check_quiet("after_reset");
        run_check("zero_tab", 1, -1, 2, 1, 1'b0, 6);

        for (int i = 0; i < LAYERS; i++) cfg_write(i, rand_entry());
        for (int r = 0; r < 8; r++) begin
            nl   = int'($urandom_range(0, 15));
            lat  = int'($urandom_range(1, 6));
            reqs = model_reqs(nl, -1);
            ab   = (reqs > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, reqs - 1)) : -1;
            reqs = model_reqs(nl, ab);
            run_check($sformatf("rand%0d", r), nl, ab, lat, reqs, ab >= 0, model_busy(reqs, lat));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
